// File: rtl/one_hot_mux.sv
// ---------------------------------------------------------------------------
// one_hot_mux
// Purpose : Selects one width_p-bit lane out of depth_p packed lanes using a
//           one-hot select vector (AND-OR form, no priority). Also provides a
//           binary index of the lowest set select bit, select-health flags,
//           a registered copy of the selected data and a sticky multi-hot
//           error flag.
// Ports   :
//   clk_i           clock for the registered outputs
//   reset_ni        asynchronous active-low reset
//   data_i          packed lanes, lane k = data_i[k*width_p +: width_p]
//   sel_one_hot_i   one-hot lane select, bit k selects lane k
//   clear_err_i     synchronous clear of the sticky error flag
//   data_o          combinational selected data (OR of all selected lanes)
//   sel_idx_o       combinational index of the lowest set select bit (0 if none)
//   none_hot_o      combinational, no select bit set
//   multi_hot_o     combinational, more than one select bit set
//   data_r_o        data_o registered on the rising clk_i edge
//   multi_hot_err_o sticky registered multi-hot flag
// ---------------------------------------------------------------------------
module one_hot_mux #(
  parameter  int width_p      = 8,
  parameter  int depth_p      = 8,
  localparam int idx_width_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [depth_p*width_p-1:0]   data_i,
  input  logic [depth_p-1:0]           sel_one_hot_i,
  input  logic                         clear_err_i,
  output logic [width_p-1:0]           data_o,
  output logic [idx_width_lp-1:0]      sel_idx_o,
  output logic                         none_hot_o,
  output logic                         multi_hot_o,
  output logic [width_p-1:0]           data_r_o,
  output logic                         multi_hot_err_o
);

  localparam logic [depth_p-1:0] one_lp = depth_p'(1);

  // Clearing the lowest set bit leaves something behind only when two or
  // more bits were set, which avoids a full popcount adder tree.
  function automatic logic is_multi_hot(input logic [depth_p-1:0] sel);
    return ((sel & (sel - one_lp)) != '0);
  endfunction

  // Binary index of the lowest set bit; 0 when no bit is set.
  function automatic logic [idx_width_lp-1:0] lowest_idx(input logic [depth_p-1:0] sel);
    logic [idx_width_lp-1:0] idx;
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int k = depth_p - 1; k >= 0; k--) begin
      if (sel[k]) begin
        idx = idx_width_lp'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [width_p-1:0]      data_s;
  logic [idx_width_lp-1:0] idx_s;
  logic                    none_s;
  logic                    multi_s;
  logic [width_p-1:0]      data_reg_r;
  logic                    err_r;

  // AND-OR lane selection plus select-health decode.
  always_comb begin
    data_s = '0;
    for (int k = 0; k < depth_p; k++) begin
      data_s = data_s | ({width_p{sel_one_hot_i[k]}} & data_i[k*width_p +: width_p]);
    end
    idx_s   = lowest_idx(sel_one_hot_i);
    none_s  = (sel_one_hot_i == '0);
    multi_s = is_multi_hot(sel_one_hot_i);
  end

  // Registered data copy and sticky multi-hot flag; clear wins over a new hit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_reg_r <= '0;
      err_r      <= 1'b0;
    end else begin
      data_reg_r <= data_s;
      if (clear_err_i) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r | multi_s;
      end
    end
  end

  assign data_o          = data_s;
  assign sel_idx_o       = idx_s;
  assign none_hot_o      = none_s;
  assign multi_hot_o     = multi_s;
  assign data_r_o        = data_reg_r;
  assign multi_hot_err_o = err_r;

endmodule

// File: tb/tb_one_hot_mux.sv
// ---------------------------------------------------------------------------
// tb_one_hot_mux
// Purpose : Self-checking bench for one_hot_mux. Combinational behaviour is
//           driven from a vector table; registered behaviour (sticky flag,
//           clear priority, asynchronous reset) by short hand-written
//           sequences. Expected values are queued when stimulus is applied
//           and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_one_hot_mux;

  logic        clk_i;
  logic        reset_ni;
  logic [63:0] data_i;
  logic [7:0]  sel_one_hot_i;
  logic        clear_err_i;
  logic [7:0]  data_o;
  logic [2:0]  sel_idx_o;
  logic        none_hot_o;
  logic        multi_hot_o;
  logic [7:0]  data_r_o;
  logic        multi_hot_err_o;

  one_hot_mux #(.width_p(8), .depth_p(8)) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .data_i          (data_i),
    .sel_one_hot_i   (sel_one_hot_i),
    .clear_err_i     (clear_err_i),
    .data_o          (data_o),
    .sel_idx_o       (sel_idx_o),
    .none_hot_o      (none_hot_o),
    .multi_hot_o     (multi_hot_o),
    .data_r_o        (data_r_o),
    .multi_hot_err_o (multi_hot_err_o)
  );

  typedef struct {
    logic [7:0] sel;
    logic [7:0] d;
    logic [2:0] idx;
    logic       none;
    logic       multi;
  } vec_t;

  typedef struct {
    logic [7:0] d_r;
    logic       err;
  } reg_exp_t;

  vec_t     vecs[12];
  vec_t     comb_q[$];
  reg_exp_t reg_q[$];

  int checks;
  int failures;

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string name);
    vec_t e;
    if (comb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=empty_queue required=entry", name);
    end else begin
      e = comb_q.pop_front();
      chk({name, ".data"},  32'(data_o),      32'(e.d));
      chk({name, ".idx"},   32'(sel_idx_o),   32'(e.idx));
      chk({name, ".none"},  32'(none_hot_o),  32'(e.none));
      chk({name, ".multi"}, 32'(multi_hot_o), 32'(e.multi));
    end
  endtask

  task automatic check_reg(input string name);
    reg_exp_t e;
    if (reg_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: actual=empty_queue required=entry", name);
    end else begin
      e = reg_q.pop_front();
      chk({name, ".data_r"}, 32'(data_r_o),        32'(e.d_r));
      chk({name, ".err"},    32'(multi_hot_err_o), 32'(e.err));
    end
  endtask

  // Drive select/clear at the falling edge, queue the register expectation,
  // then sample 1 ns after the next rising edge.
  task automatic clk_step(input logic [7:0] sel, input logic clr,
                          input logic [7:0] exp_d, input logic exp_err, input string name);
    @(negedge clk_i);
    sel_one_hot_i = sel;
    clear_err_i   = clr;
    reg_q.push_back('{exp_d, exp_err});
    @(posedge clk_i);
    #1;
    check_reg(name);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_ni      = 1'b0;
    clear_err_i   = 1'b0;
    sel_one_hot_i = 8'h00;
    data_i        = {8'h18, 8'h07, 8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

    vecs[0]  = '{8'h01, 8'hA1, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h02, 8'hB2, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{8'h04, 8'hC3, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{8'h08, 8'hD4, 3'd3, 1'b0, 1'b0};
    vecs[4]  = '{8'h10, 8'hE5, 3'd4, 1'b0, 1'b0};
    vecs[5]  = '{8'h20, 8'hF6, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{8'h40, 8'h07, 3'd6, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 8'h18, 3'd7, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{8'h30, 8'hF7, 3'd4, 1'b0, 1'b1};
    vecs[10] = '{8'hC0, 8'h1F, 3'd6, 1'b0, 1'b1};
    vecs[11] = '{8'h81, 8'hB9, 3'd0, 1'b0, 1'b1};

    // Reset state, with the combinational path live during reset.
    #2;
    reg_q.push_back('{8'h00, 1'b0});
    check_reg("reset");
    comb_q.push_back(vecs[8]);
    check_comb("reset_comb");

    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Table-driven combinational checks, 1 ns after each select change.
    for (int i = 0; i < 12; i++) begin
      sel_one_hot_i = vecs[i].sel;
      comb_q.push_back(vecs[i]);
      #1;
      check_comb($sformatf("vec%0d", i));
      #1;
    end

    // Clean up any flag left by the table, then the sticky/clear sequence.
    clk_step(8'h01, 1'b1, 8'hA1, 1'b0, "clear_init");
    clk_step(8'h30, 1'b0, 8'hF7, 1'b1, "multi_set");
    clk_step(8'h01, 1'b0, 8'hA1, 1'b1, "sticky_hold");
    clk_step(8'h01, 1'b1, 8'hA1, 1'b0, "clear");
    clk_step(8'h30, 1'b1, 8'hF7, 1'b0, "clear_prio");
    clk_step(8'h30, 1'b0, 8'hF7, 1'b1, "reset_again");
    clk_step(8'h01, 1'b0, 8'hA1, 1'b1, "pre_reset");

    // Asynchronous reset mid-cycle, no clock edge involved.
    #2;
    reset_ni = 1'b0;
    reg_q.push_back('{8'h00, 1'b0});
    #1;
    check_reg("async_reset");
    sel_one_hot_i = 8'h02;
    comb_q.push_back(vecs[1]);
    #1;
    check_comb("comb_in_reset");

    // Edges while held in reset do not capture.
    @(posedge clk_i);
    reg_q.push_back('{8'h00, 1'b0});
    #1;
    check_reg("held_reset");

    // First rising edge after release loads data_r_o.
    @(negedge clk_i);
    reset_ni = 1'b1;
    clk_step(8'h04, 1'b0, 8'hC3, 1'b0, "first_capture");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
